// File: rtl/router_xy_bp.sv
// Five-port mesh router: per-input FIFOs, round-robin grant, XY routing and
// per-direction downstream backpressure, one flit per cycle through a registered output.
module router_xy_bp #(
  parameter int DEPTH     = 4,
  parameter int DATASIZE  = 30,
  parameter int MESH_X    = 4,
  parameter int MESH_Y    = 4,
  parameter int ID_WIDTH  = 4,
  parameter int ROUTER_ID = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5*DATASIZE-1:0] data_in,
  input  logic [4:0]            valid_in,
  output logic [4:0]            full_out,
  input  logic [4:0]            full_in,
  output logic [DATASIZE-1:0]   data_out,
  output logic [4:0]            dir_out,
  output logic                  valid_out
);

  localparam int AW    = $clog2(DEPTH);
  localparam int MY_X  = ROUTER_ID % MESH_X;
  localparam int MY_Y  = ROUTER_ID / MESH_X;
  localparam int NODES = MESH_X * MESH_Y;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // One-hot direction, bit order L,S,E,N,W. Out-of-mesh IDs are parked on L.
  function automatic logic [4:0] route(input logic [DATASIZE-1:0] flit);
    int dst;
    int dx;
    int dy;
    dst = int'(flit[DATASIZE-1 -: ID_WIDTH]);
    dx  = dst % MESH_X;
    dy  = dst / MESH_X;
    if (dst >= NODES)    route = 5'b00001;
    else if (dx > MY_X)  route = 5'b00100;
    else if (dx < MY_X)  route = 5'b10000;
    else if (dy > MY_Y)  route = 5'b00010;
    else if (dy < MY_Y)  route = 5'b01000;
    else                 route = 5'b00001;
  endfunction

  logic [DATASIZE-1:0] mem [5][DEPTH];
  logic [AW-1:0]       wptr [5];
  logic [AW-1:0]       rptr [5];
  logic [AW:0]         count [5];
  logic [DATASIZE-1:0] head [5];
  logic [4:0]          head_dir [5];
  logic [4:0]          eligible;
  logic [4:0]          wr;
  logic [4:0]          rd;
  logic [2:0]          ptr;
  logic [2:0]          gnt;
  logic                any_gnt;
  logic [DATASIZE-1:0] sel_flit;
  logic [4:0]          sel_dir;

  // Head view and write acceptance; a full FIFO refuses writes even while being read.
  always_comb begin
    for (int p = 0; p < 5; p++) begin
      head[p]     = mem[p][rptr[p]];
      head_dir[p] = route(head[p]);
      full_out[p] = (count[p] == FULL_CNT);
      eligible[p] = (count[p] != '0) && ((head_dir[p] & full_in) == 5'b0);
      wr[p]       = valid_in[p] && !full_out[p];
    end
  end

  // Round-robin scan starting at ptr; the first eligible port wins.
  always_comb begin
    int idx;
    idx      = 0;
    any_gnt  = 1'b0;
    gnt      = 3'd0;
    sel_flit = '0;
    sel_dir  = 5'b0;
    for (int i = 0; i < 5; i++) begin
      idx = (int'(ptr) + i) % 5;
      if (!any_gnt && eligible[idx]) begin
        any_gnt  = 1'b1;
        gnt      = 3'(idx);
        sel_flit = head[idx];
        sel_dir  = head_dir[idx];
      end
    end
    rd = 5'b0;
    if (any_gnt) rd[gnt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < 5; p++) begin
        wptr[p]  <= '0;
        rptr[p]  <= '0;
        count[p] <= '0;
      end
    end else begin
      for (int p = 0; p < 5; p++) begin
        if (wr[p]) wptr[p] <= wptr[p] + 1'b1;
        if (rd[p]) rptr[p] <= rptr[p] + 1'b1;
        count[p] <= count[p] + {{AW{1'b0}}, wr[p]} - {{AW{1'b0}}, rd[p]};
      end
    end
  end

  // Storage needs no reset; emptiness is tracked by the counters alone.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 5; p++) begin
      if (!rst && wr[p]) mem[p][wptr[p]] <= data_in[p*DATASIZE +: DATASIZE];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      dir_out   <= 5'b0;
      data_out  <= '0;
      ptr       <= 3'd0;
    end else if (any_gnt) begin
      valid_out <= 1'b1;
      dir_out   <= sel_dir;
      data_out  <= sel_flit;
      ptr       <= (gnt == 3'd4) ? 3'd0 : gnt + 3'd1;
    end else begin
      valid_out <= 1'b0;
      dir_out   <= 5'b0;
    end
  end

endmodule

// File: tb/tb_router_xy_bp.sv
// Randomised scoreboard bench for router_xy_bp against a queue-based reference model.
module tb_router_xy_bp;

  localparam int DEPTH = 4;
  localparam int DS    = 30;
  localparam int MX    = 4;
  localparam int RID   = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [5*DS-1:0] data_in = '0;
  logic [4:0]    valid_in = 5'b0;
  logic [4:0]    full_out;
  logic [4:0]    full_in = 5'b0;
  logic [DS-1:0] data_out;
  logic [4:0]    dir_out;
  logic          valid_out;

  router_xy_bp #(.DEPTH(DEPTH), .DATASIZE(DS), .MESH_X(MX), .MESH_Y(4),
                 .ID_WIDTH(4), .ROUTER_ID(RID)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .full_out(full_out), .full_in(full_in), .data_out(data_out),
    .dir_out(dir_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [DS-1:0] d;
    logic [4:0]    dir;
  } exp_t;

  exp_t          expq[$];
  logic [DS-1:0] mq[5][$];
  int            mptr = 0;
  logic [DS-1:0] mlast = '0;
  logic [DS-1:0] din[5];
  int            checks = 0;
  int            errors = 0;
  bit            started = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Port index 0=L,1=S,2=E,3=N,4=W from the XY rule
  function automatic int routeIdx(input logic [DS-1:0] f);
    int dst, x, y;
    dst = int'(f[DS-1 -: 4]);
    x = dst % MX;
    y = dst / MX;
    if (x > RID % MX) return 2;
    if (x < RID % MX) return 4;
    if (y > RID / MX) return 1;
    if (y < RID / MX) return 3;
    return 0;
  endfunction

  function automatic logic [DS-1:0] mk(input int dst, input logic [25:0] pl);
    logic [3:0] d4;
    d4 = 4'(dst);
    return {d4, pl};
  endfunction

  task automatic applyStimulus(input logic [4:0] vin, input logic [4:0] fin, input logic r);
    exp_t e;
    int g;
    int sz[5];
    logic [4:0] mfull;
    logic [DS-1:0] f;
    @(negedge clk);
    if (started) begin
      for (int p = 0; p < 5; p++) mfull[p] = (mq[p].size() == DEPTH);
      checkOutput("full_out", 32'(full_out), 32'(mfull));
    end
    rst = r;
    valid_in = vin;
    full_in = fin;
    for (int p = 0; p < 5; p++) data_in[p*DS +: DS] = din[p];
    if (r) begin
      for (int p = 0; p < 5; p++) mq[p].delete();
      mptr = 0;
      mlast = '0;
      e = '{v: 1'b0, d: '0, dir: 5'b0};
      started = 1;
    end else begin
      for (int p = 0; p < 5; p++) sz[p] = mq[p].size();
      g = -1;
      for (int i = 0; i < 5; i++) begin
        int idx = (mptr + i) % 5;
        if (g < 0 && sz[idx] > 0 && !fin[routeIdx(mq[idx][0])]) g = idx;
      end
      if (g >= 0) begin
        f = mq[g].pop_front();
        e = '{v: 1'b1, d: f, dir: 5'(1 << routeIdx(f))};
        mlast = f;
        mptr = (g + 1) % 5;
      end else begin
        e = '{v: 1'b0, d: mlast, dir: 5'b0};
      end
      for (int p = 0; p < 5; p++)
        if (vin[p] && sz[p] < DEPTH) mq[p].push_back(din[p]);
    end
    expq.push_back(e);
  endtask

  task automatic idle(input int n, input logic [4:0] fin);
    for (int i = 0; i < n; i++) applyStimulus(5'b0, fin, 1'b0);
  endtask

  // Monitor: one expected output state per clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        checkOutput("valid_out", 32'(valid_out), 32'(e.v));
        checkOutput("dir_out", 32'(dir_out), 32'(e.dir));
        checkOutput("data_out", 32'(data_out), 32'(e.d));
      end
    end
  end

  initial begin
    int dsts[5];
    dsts = '{6, 5, 2, 14, 11};
    for (int p = 0; p < 5; p++) din[p] = mk(p + 3, 26'($urandom));
    applyStimulus(5'b11111, 5'b0, 1'b1);
    applyStimulus(5'b11111, 5'b0, 1'b1);
    idle(4, 5'b0);

    $display("[TB] single flit");
    din[0] = 30'h1C0000AB;
    applyStimulus(5'b00001, 5'b0, 1'b0);
    idle(3, 5'b0);

    $display("[TB] routing");
    for (int i = 0; i < 5; i++) begin
      din[0] = mk(dsts[i], 26'(i + 16'h100));
      applyStimulus(5'b00001, 5'b0, 1'b0);
    end
    idle(3, 5'b0);

    $display("[TB] round robin");
    for (int b = 0; b < 2; b++) begin
      for (int p = 0; p < 5; p++) din[p] = mk(7, 26'(b * 16 + p));
      applyStimulus(5'b11111, 5'b0, 1'b0);
      idle(6, 5'b0);
    end

    $display("[TB] backpressure");
    din[4] = mk(7, 26'h2A2A);
    din[3] = mk(6, 26'h3B3B);
    applyStimulus(5'b11000, 5'b00100, 1'b0);
    idle(4, 5'b00100);
    idle(3, 5'b0);

    $display("[TB] fifo full");
    for (int i = 0; i < 5; i++) begin
      din[1] = mk(14, 26'(16'h500 + i));
      applyStimulus(5'b00010, 5'b11111, 1'b0);
    end
    idle(2, 5'b11111);
    idle(8, 5'b0);

    $display("[TB] reset mid-operation");
    for (int i = 0; i < 3; i++) begin
      for (int p = 0; p < 5; p++) din[p] = mk(int'($urandom_range(0, 15)), 26'($urandom));
      applyStimulus(5'b11111, 5'b11111, 1'b0);
    end
    applyStimulus(5'b11111, 5'b0, 1'b1);
    idle(4, 5'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 5; p++) din[p] = mk(int'($urandom_range(0, 15)), 26'($urandom));
      applyStimulus(5'($urandom), 5'($urandom & $urandom), 1'b0);
    end
    idle(30, 5'b0);

    @(posedge clk);
    #2;
    checkOutput("exp_drained", 32'(expq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
